// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC comb chain.
//   beat_t      : {valid, ch, data} record passed between comb stages. Sized
//                 for the widest supported datapath; narrower instances use
//                 the low bits only.
//   clog2_min1  : channel index width, never less than one bit.
//   params_ok   : legality of a parameter set, checked at elaboration.
package cic_pkg;

   localparam int MAX_DIFF_DELAY = 2;
   localparam int BEAT_DATA_W    = 64;
   localparam int BEAT_CH_W      = 8;

   typedef struct packed {
      logic                   valid;
      logic [BEAT_CH_W-1:0]   ch;
      logic [BEAT_DATA_W-1:0] data;
   } beat_t;

   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic bit params_ok(input int width, input int out_width,
                                    input int num_ch, input int n_stages,
                                    input int diff_delay);
      return (diff_delay >= 1) && (diff_delay <= MAX_DIFF_DELAY) &&
             (num_ch >= 1) && (n_stages >= 1) &&
             (out_width <= width) && (width <= BEAT_DATA_W) &&
             (clog2_min1(num_ch) <= BEAT_CH_W);
   endfunction

endpackage

// File: rtl/cic_comb_chain_if.sv
// Valid/ready sample stream with channel tag.
//   valid, ready : handshake, transfer when both high
//   ch           : channel of the sample (CW bits)
//   data         : sample (DW bits)
// master drives valid/ch/data, slave drives ready.
interface cic_comb_chain_if #(
   parameter int DW = 64,
   parameter int CW = 2
);
   logic          valid;
   logic          ready;
   logic [CW-1:0] ch;
   logic [DW-1:0] data;

   modport master (output valid, output ch, output data, input ready);
   modport slave  (input valid, input ch, input data, output ready);
endinterface

// File: rtl/cic_comb_stage.sv
// One comb stage y = x - x[n-DIFF_DELAY] with separate history per channel.
//   clk_i, rst_i, clr_i : clock, sync reset, sync clear (same effect)
//   adv_i               : pipeline advance; when low stage and history hold
//   beat_i              : incoming beat (bubble when valid is low)
//   beat_o              : registered result beat
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int NUM_CH     = 4,
   parameter int DIFF_DELAY = 1,
   parameter int CH_W       = 2
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  clr_i,
   input  logic  adv_i,
   input  beat_t beat_i,
   output beat_t beat_o
);

   logic [WIDTH-1:0] r_hist [NUM_CH][DIFF_DELAY];
   beat_t            r_beat;
   logic [CH_W-1:0]  w_ch;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_diff;
   logic             w_unused;

   assign w_ch     = beat_i.ch[CH_W-1:0];
   assign w_x      = beat_i.data[WIDTH-1:0];
   // Wraps modulo 2^WIDTH; CIC gain growth relies on this.
   assign w_diff   = w_x - r_hist[w_ch][DIFF_DELAY-1];
   assign w_unused = ^beat_i.data;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_beat <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < DIFF_DELAY; k++) begin
               r_hist[c][k] <= '0;
            end
         end
      end else if (adv_i) begin
         r_beat.valid <= beat_i.valid;
         r_beat.ch    <= beat_i.ch;
         r_beat.data  <= BEAT_DATA_W'(w_diff);
         // Bubbles carry no sample, so they must not age the history.
         if (beat_i.valid) begin
            r_hist[w_ch][0] <= w_x;
            for (int k = 1; k < DIFF_DELAY; k++) begin
               r_hist[w_ch][k] <= r_hist[w_ch][k-1];
            end
         end
      end
   end

   assign beat_o = r_beat;

endmodule

// File: rtl/cic_comb_chain.sv
// Multi-channel N_STAGES comb section of a CIC decimator.
//   clk_i   : clock
//   rst_i   : synchronous reset, active high (priority over clr_i)
//   clr_i   : synchronous clear of history and pipeline
//   shift_i : arithmetic right shift applied to the output, quasi-static
//   s_in    : input stream (WIDTH data, channel tag)
//   m_out   : output stream (OUT_WIDTH data, channel tag)
//   err_o   : one-cycle pulse when a beat with an illegal channel is dropped
module cic_comb_chain
   import cic_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int OUT_WIDTH  = 32,
   parameter int NUM_CH     = 4,
   parameter int N_STAGES   = 5,
   parameter int DIFF_DELAY = 1,
   parameter int SHIFT_W    = 6
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic [SHIFT_W-1:0] shift_i,
   cic_comb_chain_if.slave    s_in,
   cic_comb_chain_if.master   m_out,
   output logic               err_o
);

   localparam int CH_W = clog2_min1(NUM_CH);

   if (!params_ok(WIDTH, OUT_WIDTH, NUM_CH, N_STAGES, DIFF_DELAY)) begin : g_bad_params
      $error("cic_comb_chain: illegal parameter set");
   end

   beat_t                   w_beat_in;
   beat_t                   w_chain [N_STAGES];
   logic                    w_adv;
   logic                    w_fire;
   logic                    w_legal;
   logic [CH_W-1:0]         w_in_ch;
   logic                    r_err;
   logic signed [WIDTH-1:0] w_last_data;
   logic signed [WIDTH-1:0] w_shifted;
   logic                    w_unused;

   // Global stall: the whole chain moves only when the output slot frees.
   assign w_adv      = ~w_chain[N_STAGES-1].valid | m_out.ready;
   assign s_in.ready = w_adv;
   assign w_in_ch    = s_in.ch;
   assign w_fire     = s_in.valid & w_adv;
   assign w_legal    = (32'(w_in_ch) < NUM_CH);

   // Illegal-channel beats complete the handshake but enter as bubbles.
   always_comb begin
      w_beat_in       = '0;
      w_beat_in.valid = w_fire & w_legal;
      w_beat_in.ch    = BEAT_CH_W'(w_in_ch);
      w_beat_in.data  = BEAT_DATA_W'(s_in.data);
   end

   for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
      beat_t w_stage_in;
      if (s == 0) begin : g_first
         assign w_stage_in = w_beat_in;
      end else begin : g_next
         assign w_stage_in = w_chain[s-1];
      end
      cic_comb_stage #(
         .WIDTH      (WIDTH),
         .NUM_CH     (NUM_CH),
         .DIFF_DELAY (DIFF_DELAY),
         .CH_W       (CH_W)
      ) u_stage (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .clr_i  (clr_i),
         .adv_i  (w_adv),
         .beat_i (w_stage_in),
         .beat_o (w_chain[s])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_fire & ~w_legal;
      end
   end

   assign err_o = r_err;

   // Shift amounts at or beyond WIDTH give a pure sign fill.
   assign w_last_data = w_chain[N_STAGES-1].data[WIDTH-1:0];
   assign w_shifted   = w_last_data >>> shift_i;

   assign m_out.valid = w_chain[N_STAGES-1].valid;
   assign m_out.ch    = w_chain[N_STAGES-1].ch[CH_W-1:0];
   assign m_out.data  = w_shifted[OUT_WIDTH-1:0];

   assign w_unused = ^{w_shifted, w_chain[N_STAGES-1].ch, w_chain[N_STAGES-1].data};

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain: three small configurations driven from a vector
// table, and a 5-channel/5-stage instance checked against a binomial-form
// reference through a scoreboard.
module tb_cic_comb_chain;
   import cic_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   // a: 2 ch, 2 stages, M=1   b: 2 ch, 1 stage, M=2   c: 4 ch, 1 stage, M=1
   // d: 5 ch, 5 stages, M=1
   cic_comb_chain_if #(.DW(64), .CW(1)) a_in ();
   cic_comb_chain_if #(.DW(32), .CW(1)) a_out ();
   cic_comb_chain_if #(.DW(64), .CW(1)) b_in ();
   cic_comb_chain_if #(.DW(32), .CW(1)) b_out ();
   cic_comb_chain_if #(.DW(64), .CW(2)) c_in ();
   cic_comb_chain_if #(.DW(32), .CW(2)) c_out ();
   cic_comb_chain_if #(.DW(64), .CW(3)) d_in ();
   cic_comb_chain_if #(.DW(32), .CW(3)) d_out ();
   logic       a_clr, b_clr, c_clr, d_clr;
   logic [5:0] a_sh, b_sh, c_sh, d_sh;
   logic       a_err, b_err, c_err, d_err;

   cic_comb_chain #(.NUM_CH(2), .N_STAGES(2), .DIFF_DELAY(1)) u_a (
      .clk_i(clk), .rst_i(rst), .clr_i(a_clr), .shift_i(a_sh),
      .s_in(a_in), .m_out(a_out), .err_o(a_err));
   cic_comb_chain #(.NUM_CH(2), .N_STAGES(1), .DIFF_DELAY(2)) u_b (
      .clk_i(clk), .rst_i(rst), .clr_i(b_clr), .shift_i(b_sh),
      .s_in(b_in), .m_out(b_out), .err_o(b_err));
   cic_comb_chain #(.NUM_CH(4), .N_STAGES(1), .DIFF_DELAY(1)) u_c (
      .clk_i(clk), .rst_i(rst), .clr_i(c_clr), .shift_i(c_sh),
      .s_in(c_in), .m_out(c_out), .err_o(c_err));
   cic_comb_chain #(.NUM_CH(5), .N_STAGES(5), .DIFF_DELAY(1)) u_d (
      .clk_i(clk), .rst_i(rst), .clr_i(d_clr), .shift_i(d_sh),
      .s_in(d_in), .m_out(d_out), .err_o(d_err));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- small configurations, table driven ----------------
   typedef struct {
      int          dut;
      logic [63:0] x;
      logic [5:0]  sh;
      logic [31:0] exp;
   } vec_t;

   vec_t        vt[$];
   logic [31:0] sq[$];
   int          nout, nin, t, first_t, last_t;
   logic [5:0]  last_sh;
   int          lat [3] = '{2, 1, 1};

   task automatic sm_drive(input int k, input logic v, input logic [63:0] x, input logic [5:0] sh);
      case (k)
         0: begin a_in.valid = v; a_in.data = x; a_in.ch = '0; a_sh = sh; end
         1: begin b_in.valid = v; b_in.data = x; b_in.ch = '0; b_sh = sh; end
         default: begin c_in.valid = v; c_in.data = x; c_in.ch = '0; c_sh = sh; end
      endcase
   endtask

   task automatic sm_check(input int k);
      logic        v;
      logic [31:0] d;
      case (k)
         0: begin v = a_out.valid; d = a_out.data; end
         1: begin v = b_out.valid; d = b_out.data; end
         default: begin v = c_out.valid; d = c_out.data; end
      endcase
      if (v) begin
         if (sq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL small%0d_extra: got beat %0h required none", k, d);
         end else begin
            chk($sformatf("small%0d_data", k), 64'(d), 64'(sq.pop_front()));
         end
         nout++;
         if (first_t < 0) first_t = t;
         last_t = t;
      end
   endtask

   // ---------------- 5-channel instance, scoreboard ----------------
   typedef struct {
      logic [2:0]  ch;
      logic [63:0] y;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] mh [5][6];
   int          stall_left = 0;
   int          rdy_pct    = 100;
   bit          prev_stalled = 0;
   logic [31:0] held_d;
   logic [2:0]  held_ch;

   task automatic model_clear();
      for (int c = 0; c < 5; c++)
         for (int k = 0; k < 6; k++) mh[c][k] = '0;
   endtask

   // Five cascaded first differences equal the binomial form of the input.
   task automatic model_in(input logic [2:0] c, input logic [63:0] x);
      logic [63:0] y;
      for (int k = 5; k > 0; k--) mh[c][k] = mh[c][k-1];
      mh[c][0] = x;
      y = mh[c][0] - 64'd5 * mh[c][1] + 64'd10 * mh[c][2]
        - 64'd10 * mh[c][3] + 64'd5 * mh[c][4] - mh[c][5];
      sb.push_back('{c, y});
   endtask

   task automatic mon_pop();
      exp_t               e;
      logic signed [63:0] s;
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL d_extra: got beat ch %0d data %0h required none", d_out.ch, d_out.data);
      end else begin
         e = sb.pop_front();
         s = e.y;
         s = s >>> d_sh;
         chk("d_data", 64'(d_out.data), 64'(s[31:0]));
         chk("d_ch", 64'(d_out.ch), 64'(e.ch));
      end
   endtask

   task automatic cyc(input logic v, input logic [2:0] c, input logic [63:0] x,
                      input logic clr, output bit acc);
      logic rdy;
      rdy = (stall_left == 0) && ($urandom_range(99, 0) < rdy_pct);
      if (stall_left > 0) stall_left--;
      d_in.valid = v; d_in.ch = c; d_in.data = x; d_out.ready = rdy; d_clr = clr;
      #1;
      if (prev_stalled) begin
         chk("hold_valid", 64'(d_out.valid), 64'd1);
         chk("hold_data", 64'(d_out.data), 64'(held_d));
         chk("hold_ch", 64'(d_out.ch), 64'(held_ch));
      end
      if (d_out.valid && !rdy) chk("stall_ready", 64'(d_in.ready), 64'd0);
      prev_stalled = d_out.valid && !rdy && !clr;
      held_d  = d_out.data;
      held_ch = d_out.ch;
      if (d_out.valid && rdy) mon_pop();
      acc = v && d_in.ready;
      if (acc && !clr && c < 5) model_in(c, x);
      if (clr) begin
         sb.delete();
         model_clear();
      end
      @(posedge clk); #1;
      chk("err_o", 64'(d_err), 64'(acc && !clr && c >= 5));
   endtask

   task automatic send(input logic [2:0] c, input logic [63:0] x);
      bit acc = 0;
      int n   = 0;
      while (!acc && n < 50) begin
         cyc(1'b1, c, x, 1'b0, acc);
         n++;
      end
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: beat ch %0d not accepted in 50 cycles", c);
      end
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      rdy_pct = 100;
      while (sb.size() > 0 && n < 60) begin
         cyc(1'b0, 3'd0, 64'd0, 1'b0, acc);
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
      repeat (3) cyc(1'b0, 3'd0, 64'd0, 1'b0, acc);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      rst = 1'b1;
      a_clr = 0; b_clr = 0; c_clr = 0; d_clr = 0;
      a_sh = 0; b_sh = 0; c_sh = 0; d_sh = 0;
      a_in.valid = 0; a_in.ch = 0; a_in.data = 0; a_out.ready = 1;
      b_in.valid = 0; b_in.ch = 0; b_in.data = 0; b_out.ready = 1;
      c_in.valid = 0; c_in.ch = 0; c_in.data = 0; c_out.ready = 1;
      d_in.valid = 0; d_in.ch = 0; d_in.data = 0; d_out.ready = 0;
      model_clear();

      // impulse through two stages: binomial 1,-2,1
      vt.push_back('{0, 64'd1, 6'd0, 32'd1});
      vt.push_back('{0, 64'd0, 6'd0, 32'hFFFF_FFFE});
      vt.push_back('{0, 64'd0, 6'd0, 32'd1});
      vt.push_back('{0, 64'd0, 6'd0, 32'd0});
      // step with M=2
      vt.push_back('{1, 64'd5, 6'd0, 32'd5});
      vt.push_back('{1, 64'd5, 6'd0, 32'd5});
      vt.push_back('{1, 64'd5, 6'd0, 32'd0});
      vt.push_back('{1, 64'd5, 6'd0, 32'd0});
      // wrap and shift
      vt.push_back('{2, 64'h7FFF_FFFF_FFFF_FFFF, 6'd0,  32'hFFFF_FFFF});
      vt.push_back('{2, 64'h8000_0000_0000_0000, 6'd0,  32'd1});
      vt.push_back('{2, 64'h0,                   6'd4,  32'd0});
      vt.push_back('{2, 64'h100,                 6'd4,  32'h10});
      vt.push_back('{2, 64'h0,                   6'd4,  32'hFFFF_FFF0});
      vt.push_back('{2, 64'hFFFF_FFFF_FFFF_FFF0, 6'd63, 32'hFFFF_FFFF});
      vt.push_back('{2, 64'h7FFF_FFFF_FFFF_FFF0, 6'd32, 32'h8000_0000});

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_valid", 64'(d_out.valid), 64'd0);
      chk("rst_ready", 64'(d_in.ready), 64'd1);
      chk("rst_err", 64'(d_err), 64'd0);
      chk("rst_data", 64'(d_out.data), 64'd0);
      chk("rst_ch", 64'(d_out.ch), 64'd0);

      for (int k = 0; k < 3; k++) begin
         sq.delete();
         nout = 0; nin = 0; t = 0; first_t = -1; last_t = -1; last_sh = 0;
         foreach (vt[i]) begin
            if (vt[i].dut == k) begin
               sm_drive(k, 1'b1, vt[i].x, vt[i].sh);
               last_sh = vt[i].sh;
               sq.push_back(vt[i].exp);
               nin++;
               @(posedge clk); #1; t++;
               sm_check(k);
            end
         end
         sm_drive(k, 1'b0, 64'd0, last_sh);
         repeat (4) begin
            @(posedge clk); #1; t++;
            sm_check(k);
         end
         chk($sformatf("small%0d_count", k), 64'(nout), 64'(nin));
         chk($sformatf("small%0d_latency", k), 64'(first_t), 64'(lat[k]));
         chk($sformatf("small%0d_contig", k), 64'(last_t - first_t + 1), 64'(nout));
      end

      // interleaved constants, then one step on channel 2
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) send(3'(c), 64'(10 * (c + 1)));
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) send(3'(c), (c == 2) ? 64'd31 : 64'(10 * (c + 1)));
      drain();

      // backpressure while streaming
      for (int i = 0; i < 20; i++) begin
         if (i == 8) stall_left = 5;
         send(3'(i % 4), 64'(1000 + i * 37));
      end
      drain();

      // clear mid-stream with a simultaneous beat, then restart from zero history
      for (int i = 0; i < 6; i++) send(3'(i % 4), 64'(500 + i));
      cyc(1'b1, 3'd1, 64'd999, 1'b1, acc);
      chk("clr_ready", 64'(acc), 64'd1);
      send(3'd1, 64'h1234);
      send(3'd3, 64'h55);
      drain();

      // illegal channel: handshake completes, err pulses, no output beat
      send(3'd5, 64'd77);
      cyc(1'b0, 3'd0, 64'd0, 1'b0, acc);
      send(3'd0, 64'd8);
      drain();

      // reset while stalled with a full pipeline
      stall_left = 1000;
      for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i % 5), 64'(i + 3), 1'b0, acc);
      d_out.ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rststall_ready", 64'(d_in.ready), 64'd1);
      chk("rststall_valid", 64'(d_out.valid), 64'd0);
      sb.delete();
      model_clear();
      stall_left = 0;
      prev_stalled = 0;

      // random traffic, random backpressure, nonzero shift
      d_sh = 6'd3;
      rdy_pct = 70;
      for (int i = 0; i < 150; i++)
         send(3'($urandom_range(6, 0)), {$urandom, $urandom});
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
